led_pwm_ctrl: RTL
=================

// Module: led_pwm_ctrl
// PURPOSE
//  RGB LED PWM driver that consumes fields of the AXI-Lite register file's slv_reg outputs and drives the board LED pins.
//  Replaces the direct slv_reg-bit-to-LED wiring with per-channel brightness control.
//  Duty values are double-buffered and take effect only at a PWM period boundary, so there are no glitches.
//  Runs in the axi_aclk domain.
// PARAMETERS
//  NUM_CH      3   number of PWM channels (R,G,B)
//  PWM_BITS    8   duty/counter width; period = 2**PWM_BITS ticks
//  PRESC_BITS  16  width of prescale input
// PORTS
//  axi_aclk     in   1                  clock
//  axi_aresetn  in   1                  reset, asynchronous, active-low
//  enable       in   1                  run PWM; 0 = hold counters and drive outputs off
//  prescale     in   PRESC_BITS         a tick occurs every prescale+1 clocks
//  invert       in   1                  1 = active-low LED pins
//  duty         in   NUM_CH*PWM_BITS    channel i duty is in bits [i*PWM_BITS +: PWM_BITS]
//  duty_wr      in   1                  1-cycle pulse: capture duty into the shadow register
//  pwm_out      out  NUM_CH             registered PWM pins
//  period_start out  1                  1-cycle pulse when the PWM counter wraps to 0
//  pending      out  1                  shadow holds a duty not yet applied
// BEHAVIOUR
//  Reset values (all): presc_cnt=0, pwm_cnt=0, shadow=0, active=0, pending=0, pwm_out=0, period_start=0.
//  Prescaler
//   - counts 0..prescale; tick is asserted in the cycle where presc_cnt==prescale, and presc_cnt then returns to 0.
//   - prescale=0: tick every clock.
//   - prescale changed mid-count: compare uses the live value; if presc_cnt>prescale, count on and wrap at 2**PRESC_BITS-1.
//  PWM counter
//   - pwm_cnt increments on tick and wraps 2**PWM_BITS-1 -> 0.
//   - period_start is registered and asserts for 1 cycle on the tick where pwm_cnt wraps to 0.
//  Duty load
//   - duty_wr: shadow<=duty, pending<=1.
//   - On a wrapping tick with pending=1: active<=shadow, pending<=0.
//   - duty_wr in the same cycle as the wrap: active takes the OLD shadow; the new value goes to shadow; pending stays 1.
//   - Back-to-back duty_wr before a wrap: the last write wins.
//  Output
//   - pwm_out[i] <= (pwm_cnt < eff_duty[i]) ^ invert. Registered: 1 clock after pwm_cnt.
//   - duty=0: always off. duty=2**PWM_BITS-1: on for 255 of 256 ticks (no 100%).
//  enable=0
//   - presc_cnt and pwm_cnt are cleared and held at 0.
//   - pwm_out=invert (LED off); period_start=0.
//   - duty_wr is still accepted; active loads from shadow immediately while disabled.
//   - On re-enable, counting starts from 0 and the first period_start fires at the first wrap.
//  Reset mid-period: all state clears asynchronously; the first edge after release behaves as after power-up.
// CONFIGURATION
//  Macro LED_BREATHE_EN.
//  Defined:
//   - adds input port breathe_en (1 bit).
//   - adds an internal PWM_BITS ramp register with a direction flag, reset to ramp=0 and direction up.
//   - While breathe_en=1, on each wrap the ramp steps by +/-1 as a triangle: it reverses at 2**PWM_BITS-1 and at 0.
//   - eff_duty[i] = (active[i]*ramp) >> PWM_BITS, using a 2*PWM_BITS product.
//   - While breathe_en=0: ramp holds and eff_duty=active.
//  Not defined: no port, no ramp logic; eff_duty=active.
// TESTING
//  1. Reset release, prescale=0, duty_wr with R=0x40, G=0, B=0xFF
//     -> the first period after the next wrap has R high for 64 clocks, G never high, B high for 255 clocks.
//  2. prescale=3 -> ticks every 4 clocks; period_start every 1024 clocks; pending falls the cycle after the wrap.
//  3. duty_wr coincident with the wrap tick -> the old shadow is applied; the new duty appears one period later; pending=1 in between.
//  4. invert=1, duty=0 -> pwm_out stays all-1; enable=0 mid-period -> pwm_out=invert next clock, counters=0.
//  5. Assert axi_aresetn low mid-period with duty 0x80 -> outputs 0 immediately; the duty must be rewritten to resume.
//  6. LED_BREATHE_EN, active=0xFF, breathe_en=1, prescale=0
//     -> ramp=1 after the first wrap; ramp peaks at 255 after 255 periods, then decrements.

Source files
------------

// File: rtl/led_pwm_ctrl.sv
// RGB LED PWM driver with double-buffered duty applied at period boundaries.
// Optional LED_BREATHE_EN adds a breathe_en input that scales duty by a triangle ramp.
module led_pwm_ctrl #(
  parameter int NUM_CH     = 3,
  parameter int PWM_BITS   = 8,
  parameter int PRESC_BITS = 16
) (
  input  logic                       axi_aclk,
  input  logic                       axi_aresetn,
  input  logic                       enable,
  input  logic [PRESC_BITS-1:0]      prescale,
  input  logic                       invert,
  input  logic [NUM_CH*PWM_BITS-1:0] duty,
  input  logic                       duty_wr,
`ifdef LED_BREATHE_EN
  input  logic                       breathe_en,
`endif
  output logic [NUM_CH-1:0]          pwm_out,
  output logic                       period_start,
  output logic                       pending
);

  localparam logic [PRESC_BITS-1:0] PRESC_ONE = 1;
  localparam logic [PWM_BITS-1:0]   PWM_ONE   = 1;
  localparam logic [PWM_BITS-1:0]   PWM_MAX   = '1;

  logic [PRESC_BITS-1:0]      presc_cnt_q, presc_cnt_d;
  logic [PWM_BITS-1:0]        pwm_cnt_q, pwm_cnt_d;
  logic [NUM_CH*PWM_BITS-1:0] shadow_q, shadow_d;
  logic [NUM_CH*PWM_BITS-1:0] active_q, active_d;
  logic                       pending_q, pending_d;
  logic [NUM_CH-1:0]          pwm_out_q, pwm_out_d;
  logic                       period_start_q, period_start_d;
  logic                       tick, wrap, load;
  logic [NUM_CH-1:0][PWM_BITS-1:0] eff_duty;

`ifdef LED_BREATHE_EN
  logic [PWM_BITS-1:0]               ramp_q, ramp_d;
  logic                              ramp_up_q, ramp_up_d;
  logic [NUM_CH-1:0][2*PWM_BITS-1:0] prod;
`endif

  always_comb begin
    eff_duty = '0;
`ifdef LED_BREATHE_EN
    prod = '0;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
`ifdef LED_BREATHE_EN
      prod[i] = {{PWM_BITS{1'b0}}, active_q[i*PWM_BITS +: PWM_BITS]} * {{PWM_BITS{1'b0}}, ramp_q};
      eff_duty[i] = breathe_en ? prod[i][2*PWM_BITS-1:PWM_BITS] : active_q[i*PWM_BITS +: PWM_BITS];
`else
      eff_duty[i] = active_q[i*PWM_BITS +: PWM_BITS];
`endif
    end
  end

  always_comb begin
    // Live prescale compare: if it drops below the count, the counter rolls over naturally.
    tick = enable && (presc_cnt_q == prescale);
    wrap = tick && (pwm_cnt_q == PWM_MAX);

    presc_cnt_d = (!enable || tick) ? '0 : presc_cnt_q + PRESC_ONE;
    if (!enable)   pwm_cnt_d = '0;
    else if (tick) pwm_cnt_d = pwm_cnt_q + PWM_ONE;
    else           pwm_cnt_d = pwm_cnt_q;

    period_start_d = wrap;

    // While disabled there is no period to protect, so pending duty applies at once.
    load      = pending_q && (wrap || !enable);
    active_d  = load ? shadow_q : active_q;
    shadow_d  = duty_wr ? duty : shadow_q;
    pending_d = duty_wr ? 1'b1 : (load ? 1'b0 : pending_q);

    pwm_out_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pwm_out_d[i] = enable ? ((pwm_cnt_q < eff_duty[i]) ^ invert) : invert;
    end

`ifdef LED_BREATHE_EN
    ramp_d    = ramp_q;
    ramp_up_d = ramp_up_q;
    if (wrap && breathe_en) begin
      if (ramp_up_q) begin
        ramp_d = ramp_q + PWM_ONE;
        if (ramp_q == PWM_MAX - PWM_ONE) ramp_up_d = 1'b0;
      end else begin
        ramp_d = ramp_q - PWM_ONE;
        if (ramp_q == PWM_ONE) ramp_up_d = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      presc_cnt_q    <= '0;
      pwm_cnt_q      <= '0;
      shadow_q       <= '0;
      active_q       <= '0;
      pending_q      <= 1'b0;
      pwm_out_q      <= '0;
      period_start_q <= 1'b0;
`ifdef LED_BREATHE_EN
      ramp_q         <= '0;
      ramp_up_q      <= 1'b1;
`endif
    end else begin
      presc_cnt_q    <= presc_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      pwm_out_q      <= pwm_out_d;
      period_start_q <= period_start_d;
`ifdef LED_BREATHE_EN
      ramp_q         <= ramp_d;
      ramp_up_q      <= ramp_up_d;
`endif
    end
  end

  assign pwm_out      = pwm_out_q;
  assign period_start = period_start_q;
  assign pending      = pending_q;

endmodule
